// File: rtl/ctrl_pkg.sv
// ctrl_pkg: RV32I opcodes, control-word layout and per-opcode control words
package ctrl_pkg;
  localparam int CTRL_W = 11;
  localparam int B_JMP = 0;
  localparam int B_BRA = 1;
  localparam int B_MEM2REG = 2;
  localparam int B_REG_W = 3;
  localparam int B_MEM_W = 4;
  localparam int B_EXEC_B = 5;
  localparam int B_EXEC_A = 6;
  localparam logic [6:0] F_JMP = 7'b1 << B_JMP;
  localparam logic [6:0] F_BRA = 7'b1 << B_BRA;
  localparam logic [6:0] F_M2R = 7'b1 << B_MEM2REG;
  localparam logic [6:0] F_RW = 7'b1 << B_REG_W;
  localparam logic [6:0] F_MW = 7'b1 << B_MEM_W;
  localparam logic [6:0] F_B = 7'b1 << B_EXEC_B;
  localparam logic [6:0] F_A = 7'b1 << B_EXEC_A;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_RTYPE = 4'd1;
  localparam logic [3:0] ALU_ITYPE = 4'd2;
  localparam logic [3:0] ALU_BRANCH = 4'd3;
  localparam logic [3:0] ALU_PASS_B = 4'd4;
  localparam logic [3:0] ALU_SYS = 4'd5;
  typedef enum logic [6:0] {
    OP_R = 7'b0110011,
    OP_I_JUMP = 7'b1100111,
    OP_I_LOAD = 7'b0000011,
    OP_I_ARITH = 7'b0010011,
    OP_I_SYS = 7'b1110011,
    OP_I_FENCE = 7'b0001111,
    OP_S = 7'b0100011,
    OP_B = 7'b1100011,
    OP_U_LUI = 7'b0110111,
    OP_U_AUIPC = 7'b0010111,
    OP_J = 7'b1101111
  } opcode_e;
  localparam logic [CTRL_W-1:0] CW_R = {ALU_RTYPE, F_RW};
  localparam logic [CTRL_W-1:0] CW_I_JUMP = {ALU_ADD, F_B | F_RW | F_JMP};
  localparam logic [CTRL_W-1:0] CW_I_LOAD = {ALU_ADD, F_B | F_RW | F_M2R};
  localparam logic [CTRL_W-1:0] CW_I_ARITH = {ALU_ITYPE, F_B | F_RW};
  localparam logic [CTRL_W-1:0] CW_I_SYS = {ALU_SYS, F_RW};
  localparam logic [CTRL_W-1:0] CW_I_FENCE = {ALU_ADD, 7'b0};
  localparam logic [CTRL_W-1:0] CW_S = {ALU_ADD, F_B | F_MW};
  localparam logic [CTRL_W-1:0] CW_B = {ALU_BRANCH, F_BRA};
  localparam logic [CTRL_W-1:0] CW_U_LUI = {ALU_PASS_B, F_B | F_RW};
  localparam logic [CTRL_W-1:0] CW_U_AUIPC = {ALU_ADD, F_A | F_B | F_RW};
  localparam logic [CTRL_W-1:0] CW_J = {ALU_ADD, F_A | F_B | F_RW | F_JMP};
endpackage

// File: rtl/ctrl_pipe_decode.sv
// ctrl_decode: combinational opcode to control word, flags unrecognised opcodes
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]        opcode_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              legal_o
);
  // table lookup; unknown opcodes give an all-zero word
  always_comb begin
    ctrl_o = '0;
    legal_o = 1'b1;
    case (opcode_i)
      OP_R: ctrl_o = CW_R;
      OP_I_JUMP: ctrl_o = CW_I_JUMP;
      OP_I_LOAD: ctrl_o = CW_I_LOAD;
      OP_I_ARITH: ctrl_o = CW_I_ARITH;
      OP_I_SYS: ctrl_o = CW_I_SYS;
      OP_I_FENCE: ctrl_o = CW_I_FENCE;
      OP_S: ctrl_o = CW_S;
      OP_B: ctrl_o = CW_B;
      OP_U_LUI: ctrl_o = CW_U_LUI;
      OP_U_AUIPC: ctrl_o = CW_U_AUIPC;
      OP_J: ctrl_o = CW_J;
      default: legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: registered control-word stage chain with stall/flush; CTRL_ILLEGAL_TRAP_EN adds the illegal flag
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [6:0]               opcode,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     in_ready,
  output logic [STAGES*CTRL_W-1:0] ctrl_flat,
  output logic [STAGES-1:0]        valid_flat
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                     illegal
`endif
);
  logic [CTRL_W-1:0] dec_word;
  logic dec_legal;
  logic [STAGES-1:0][CTRL_W:0] st_q;
  ctrl_decode u_dec (.opcode_i(opcode), .ctrl_o(dec_word), .legal_o(dec_legal));
  assign in_ready = !stall;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CTRL_W:0] d, q;
    if (k == 0) begin : g_head
      // stage 0 empties on flush, holds on stall, otherwise captures the decoded input
      always_comb d = flush ? '0 : stall ? q : in_valid ? {1'b1, dec_word} : '0;
    end else begin : g_tail
      logic bubble;
      // later stages shift; flush kills the young ones, stall drops a bubble into stage 1
      always_comb begin
        bubble = flush ? (k < FLUSH_DEPTH) : (stall && k == 1);
        d = bubble ? '0 : st_q[k-1];
      end
    end
    // stage register holding {valid, word}
    always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else q <= d;
    end
    assign st_q[k] = q;
    assign ctrl_flat[k*CTRL_W +: CTRL_W] = q[CTRL_W-1:0];
    assign valid_flat[k] = q[CTRL_W];
  end
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic ill_d, ill_q;
  // flag follows stage 0: cleared by flush, held by stall
  always_comb ill_d = flush ? 1'b0 : stall ? ill_q : in_valid && !dec_legal;
  // illegal flag register
  always_ff @(posedge clk) begin
    if (rst) ill_q <= 1'b0;
    else ill_q <= ill_d;
  end
  assign illegal = ill_q;
`else
  logic unused_legal;
  assign unused_legal = dec_legal;
`endif
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed + random scoreboard bench for ctrl_pipe; honours CTRL_ILLEGAL_TRAP_EN
module tb_ctrl_pipe;
  import ctrl_pkg::*;
  localparam int S = 3;
  localparam int FD = 2;
  localparam int W = S * CTRL_W;
  logic clk = 0, rst = 1, in_valid = 0, stall = 0, flush = 0;
  logic [6:0] opcode = '0;
  logic in_ready;
  logic [W-1:0] ctrl_flat;
  logic [S-1:0] valid_flat;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal;
`endif
  typedef struct packed {
    logic [W-1:0] c;
    logic [S-1:0] v;
    logic ill;
  } exp_t;
  exp_t sb[$];
  logic [CTRL_W-1:0] mc[S];
  logic mv[S];
  logic mill;
  int n_tests = 0, n_fail = 0;
  logic [6:0] ops[12] = '{7'b0110011, 7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011, 7'b0001111,
                          7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0000000};
  always #5 clk = ~clk;
  ctrl_pipe #(.STAGES(S), .FLUSH_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .stall(stall), .flush(flush),
    .in_ready(in_ready), .ctrl_flat(ctrl_flat), .valid_flat(valid_flat)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );
  function automatic logic [CTRL_W:0] ref_dec(input logic [6:0] op);
    case (op)
      7'b0110011: return {1'b1, 11'b0001_0001000};
      7'b1100111: return {1'b1, 11'b0000_0101001};
      7'b0000011: return {1'b1, 11'b0000_0101100};
      7'b0010011: return {1'b1, 11'b0010_0101000};
      7'b1110011: return {1'b1, 11'b0101_0001000};
      7'b0001111: return {1'b1, 11'b0000_0000000};
      7'b0100011: return {1'b1, 11'b0000_0110000};
      7'b1100011: return {1'b1, 11'b0011_0000010};
      7'b0110111: return {1'b1, 11'b0100_0101000};
      7'b0010111: return {1'b1, 11'b0000_1101000};
      7'b1101111: return {1'b1, 11'b0000_1101001};
      default: return '0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic [6:0] op, input logic st = 0, input logic fl = 0,
                      input logic rs = 0);
    logic [CTRL_W-1:0] nc[S];
    logic nv[S];
    logic [CTRL_W:0] d;
    exp_t e;
    rst = rs; in_valid = v; opcode = op; stall = st; flush = fl;
    #1 chk("in_ready", 64'(in_ready), 64'(!st));
    d = ref_dec(op);
    for (int k = 1; k < S; k++) begin
      nc[k] = mc[k-1];
      nv[k] = mv[k-1];
    end
    nv[0] = v;
    nc[0] = v ? d[CTRL_W-1:0] : '0;
    if (rs) begin
      for (int k = 0; k < S; k++) begin nv[k] = 0; nc[k] = '0; end
      mill = 0;
    end else if (fl) begin
      for (int k = 0; k < FD; k++) begin nv[k] = 0; nc[k] = '0; end
      mill = 0;
    end else if (st) begin
      nv[0] = mv[0]; nc[0] = mc[0];
      nv[1] = 0; nc[1] = '0;
    end else mill = v && !d[CTRL_W];
    mc = nc;
    mv = nv;
    for (int k = 0; k < S; k++) begin
      e.c[k*CTRL_W +: CTRL_W] = mc[k];
      e.v[k] = mv[k];
    end
    e.ill = mill;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("ctrl_flat", 64'(ctrl_flat), 64'(e.c));
    chk("valid_flat", 64'(valid_flat), 64'(e.v));
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("illegal", 64'(illegal), 64'(e.ill));
`endif
  endtask
  initial begin
    for (int k = 0; k < S; k++) begin mc[k] = '0; mv[k] = 0; end
    mill = 0;
    step(0, 7'h00, 0, 0, 1);
    chk("rst_ctrl", 64'(ctrl_flat), 64'(0));
    chk("rst_valid", 64'(valid_flat), 64'(0));
    step(1, OP_R);
    chk("r_s0_regw", 64'(ctrl_flat[3]), 64'(1));
    chk("r_s0_valid", 64'(valid_flat[0]), 64'(1));
    step(0, 7'h00);
    step(0, 7'h00);
    chk("r_s2_word", 64'(ctrl_flat[32:22]), 64'(11'b0001_0001000));
    chk("r_s2_valid", 64'(valid_flat[2]), 64'(1));
    step(1, OP_I_LOAD);
    step(1, OP_S);
    step(1, OP_B);
    step(1, OP_J);
    chk("stream_s0_j", 64'(ctrl_flat[10:0]), 64'(11'b0000_1101001));
    chk("stream_s1_b", 64'(ctrl_flat[21:11]), 64'(11'b0011_0000010));
    chk("stream_s2_s", 64'(ctrl_flat[32:22]), 64'(11'b0000_0110000));
    step(0, 7'h00);
    step(0, 7'h00);
    step(1, OP_I_LOAD);
    step(1, OP_R, 1);
    chk("stall1_s0", 64'(ctrl_flat[10:0]), 64'(11'b0000_0101100));
    chk("stall1_s1", 64'({valid_flat[1], ctrl_flat[21:11]}), 64'(0));
    step(1, OP_R, 1);
    chk("stall2_s0", 64'(ctrl_flat[10:0]), 64'(11'b0000_0101100));
    chk("stall2_s1", 64'({valid_flat[1], ctrl_flat[21:11]}), 64'(0));
    chk("stall2_s2", 64'({valid_flat[2], ctrl_flat[32:22]}), 64'(0));
    step(1, OP_R);
    chk("unstall_s1", 64'(ctrl_flat[21:11]), 64'(11'b0000_0101100));
    step(1, OP_R);
    step(1, OP_S);
    step(1, OP_B);
    step(1, OP_J, 1, 1);
    chk("flush_valid", 64'(valid_flat), 64'(3'b100));
    chk("flush_s2_s", 64'(ctrl_flat[32:22]), 64'(11'b0000_0110000));
    step(1, OP_I_JUMP);
    step(1, OP_U_LUI);
    step(1, OP_U_AUIPC);
    chk("full_valid", 64'(valid_flat), 64'(3'b111));
    step(1, OP_R, 0, 0, 1);
    chk("midrst_ctrl", 64'(ctrl_flat), 64'(0));
    chk("midrst_valid", 64'(valid_flat), 64'(0));
    step(1, OP_I_ARITH);
    chk("refill_s0", 64'(ctrl_flat[10:0]), 64'(11'b0010_0101000));
    chk("refill_valid", 64'(valid_flat), 64'(3'b001));
    step(1, 7'b0000000);
    chk("illop_s0", 64'({valid_flat[0], ctrl_flat[10:0]}), 64'(12'h800));
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_set", 64'(illegal), 64'(1));
`endif
    step(1, OP_R, 1);
    step(1, OP_R);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_clear", 64'(illegal), 64'(0));
`endif
    step(1, 7'b1111111);
    step(0, 7'h00, 0, 1);
    step(0, 7'b0000000);
    for (int i = 0; i < 80; i++)
      step(1'($urandom), ($urandom_range(0, 3) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)],
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
